add24_arbiter: RTL and testbench
================================

ADD24_ARBITER -- requirements
Module: add24_arbiter

Interface
REQ-001 Parameter: ARB_MODE, default 0, arbitration policy (0 = round-robin, 1 = fixed priority with req0 highest).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req0_valid  input  1  requester 0 has an operation pending.
REQ-005 Port: req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 Port: req0_a, req0_b  input  24 each  requester 0 operands.
REQ-007 Port: req0_cin  input  1  requester 0 carry-in.
REQ-008 Port: req1_valid, req1_ready, req1_a, req1_b, req1_cin  same widths/directions/meanings as REQ-004..007, for requester 1.
REQ-009 Port: adder_a, adder_b  output  24 each  registered operands driven to the shared 24-bit prefix adder.
REQ-010 Port: adder_kin  output  2  carry-in in kill/generate encoding (2'b00 = carry 0, 2'b11 = carry 1); other codes never driven.
REQ-011 Port: adder_sum  input  25  combinational adder result for adder_a + adder_b + carry.
REQ-012 Port: res_valid  output  1  res_sum/res_id hold a result.
REQ-013 Port: res_ready  input  1  consumer accepts result when high with res_valid.
REQ-014 Port: res_sum  output  25  registered result; bit 24 = carry-out.
REQ-015 Port: res_id  output  1  requester that issued the result.
REQ-016 Port: busy  output  1  high when either pipeline stage holds a valid entry.

Function
REQ-017 Two-stage pipeline: stage S1 = operand register (adder_a/b/kin + id + s1_valid); stage S2 = result register (res_sum/res_id/res_valid).
REQ-018 S2 load condition: s1_valid && (!res_valid || res_ready); on load, res_sum <= adder_sum, res_id <= S1 id, res_valid <= 1.
REQ-019 S2 clear: res_valid && res_ready && !(S2 load) -> res_valid <= 0 next cycle.
REQ-020 S1 accept condition (can_accept): !s1_valid || S2 load.
REQ-021 Grant is combinational; reqN_ready = grantN && can_accept; at most one reqN_ready high per cycle; ready never high for a requester with valid low.
REQ-022 Acceptance (reqN_valid && reqN_ready) captures reqN_a/b into adder_a/b, cin into adder_kin per REQ-010, N into S1 id, s1_valid <= 1.
REQ-023 S1 vacates (s1_valid <= 0) when S2 load occurs without a new acceptance.
REQ-024 Latency: acceptance at edge k -> res_valid high after edge k+1 (two cycles from request with valid high, ready high).
REQ-025 Throughput: one operation per cycle sustained while res_ready held high.
REQ-026 ARB_MODE 0: only one valid -> grant it; both valid -> grant the requester not in last_grant; last_grant updates only on acceptance.
REQ-027 ARB_MODE 1: req0 granted whenever req0_valid; req1 granted only when req0_valid low.
REQ-028 Backpressure: res_ready low with both stages full -> both reqN_ready low; no result overwritten, dropped or duplicated.
REQ-029 Operand/result changes while held: adder_a/b/kin and res_sum/res_id stable while respective stage full and not advancing.
REQ-030 Arithmetic: res_sum = {1'b0,a} + {1'b0,b} + cin, modulo 2^25 never wraps (max 25'h1FFFFFF).
REQ-031 busy = s1_valid | res_valid.

Reset
REQ-032 rst_n low, asynchronously: s1_valid, res_valid = 0; adder_a, adder_b = 0; adder_kin = 2'b00; res_sum = 0; res_id = 0; last_grant = 1 (req0 favoured first).
REQ-033 Reset mid-operation discards all in-flight entries; no res_valid pulse after rst_n release until a new acceptance.
REQ-034 reqN_ready low throughout reset.

Verification
REQ-035 req0 a=24'hFFFFFF b=24'h000001 cin=0, res_ready=1 -> two cycles later res_valid=1, res_sum=25'h1000000, res_id=0.
REQ-036 req1 a=24'hFFFFFF b=24'hFFFFFF cin=1 -> res_sum=25'h1FFFFFF, res_id=1, adder_kin=2'b11 during S1.
REQ-037 ARB_MODE 0, both valid continuously, res_ready=1 -> accepted ids 0,1,0,1..., one result per cycle.
REQ-038 res_ready=0 for 5 cycles, both requesters valid -> exactly 2 accepts, then readies low; on res_ready=1 results drain in order, none lost.
REQ-039 rst_n pulsed low with S1 and S2 full -> res_valid=0, busy=0 immediately; next grant with both valid goes to req0.
REQ-040 ARB_MODE 1, both valid for 4 cycles -> only req0 accepted; req1 accepted first cycle req0_valid drops.

Source files
------------

// File: rtl/add24_arbiter.sv
// Two-requester front end for a shared 24-bit adder: arbitrates one operation per
// cycle into an operand register (S1) and captures the adder result into S2.
module add24_arbiter #(
  parameter int ARB_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [23:0] req0_a,
  input  logic [23:0] req0_b,
  input  logic        req0_cin,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [23:0] req1_a,
  input  logic [23:0] req1_b,
  input  logic        req1_cin,
  output logic [23:0] adder_a,
  output logic [23:0] adder_b,
  output logic [1:0]  adder_kin,
  input  logic [24:0] adder_sum,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [24:0] res_sum,
  output logic        res_id,
  output logic        busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, ready may depend combinationally on valid.

  logic s1_valid;
  logic s1_id;
  logic last_grant;
  logic s2_load;
  logic can_accept;
  logic grant0;
  logic grant1;
  logic take0;
  logic take1;

  always_comb begin
    s2_load    = s1_valid && (!res_valid || res_ready);
    can_accept = !s1_valid || s2_load;
    grant0     = 1'b0;
    grant1     = 1'b0;
    if (ARB_MODE == 1) begin
      grant0 = req0_valid;
      grant1 = req1_valid && !req0_valid;
    end else begin
      // On contention the requester not served last wins.
      grant0 = req0_valid && (!req1_valid || last_grant);
      grant1 = req1_valid && (!req0_valid || !last_grant);
    end
    req0_ready = rst_n && grant0 && can_accept;
    req1_ready = rst_n && grant1 && can_accept;
    take0      = req0_valid && req0_ready;
    take1      = req1_valid && req1_ready;
    busy       = s1_valid || res_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_id      <= 1'b0;
      adder_a    <= 24'd0;
      adder_b    <= 24'd0;
      adder_kin  <= 2'b00;
      last_grant <= 1'b1;
      res_valid  <= 1'b0;
      res_sum    <= 25'd0;
      res_id     <= 1'b0;
    end else begin
      if (take0) begin
        adder_a    <= req0_a;
        adder_b    <= req0_b;
        adder_kin  <= {2{req0_cin}};
        s1_id      <= 1'b0;
        s1_valid   <= 1'b1;
        last_grant <= 1'b0;
      end else if (take1) begin
        adder_a    <= req1_a;
        adder_b    <= req1_b;
        adder_kin  <= {2{req1_cin}};
        s1_id      <= 1'b1;
        s1_valid   <= 1'b1;
        last_grant <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        res_sum   <= adder_sum;
        res_id    <= s1_id;
        res_valid <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_add24_arbiter.sv
// Bench for add24_arbiter: drives a round-robin and a fixed-priority instance with
// shared stimulus and checks each against its own reference scoreboard.
module tb_add24_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_cin, req1_cin, res_ready;
  logic [23:0] req0_a, req0_b, req1_a, req1_b;

  logic [1:0]  r0_rdy, r1_rdy, rv, rid, bsy;
  logic [23:0] aa [2];
  logic [23:0] ab [2];
  logic [1:0]  kin [2];
  logic [24:0] asum [2];
  logic [24:0] rsum [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cnt [2];
  logic last_acc [2];

  // entry: {accept cycle[31:0], id, sum[24:0]}
  logic [57:0] exp_q0[$];
  logic [57:0] exp_q1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The shared adder the design drives, one per instance.
  assign asum[0] = {1'b0, aa[0]} + {1'b0, ab[0]} + {24'd0, kin[0] == 2'b11};
  assign asum[1] = {1'b0, aa[1]} + {1'b0, ab[1]} + {24'd0, kin[1] == 2'b11};

  add24_arbiter #(.ARB_MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(r0_rdy[0]), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(r1_rdy[0]), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .adder_a(aa[0]), .adder_b(ab[0]), .adder_kin(kin[0]), .adder_sum(asum[0]),
    .res_valid(rv[0]), .res_ready(res_ready), .res_sum(rsum[0]), .res_id(rid[0]), .busy(bsy[0])
  );

  add24_arbiter #(.ARB_MODE(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(r0_rdy[1]), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(r1_rdy[1]), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .adder_a(aa[1]), .adder_b(ab[1]), .adder_kin(kin[1]), .adder_sum(asum[1]),
    .res_valid(rv[1]), .res_ready(res_ready), .res_sum(rsum[1]), .res_id(rid[1]), .busy(bsy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int qsize(input int m);
    return (m == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [57:0] qhead(input int m);
    if (qsize(m) == 0) return 58'd0;
    return (m == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic qpop(input int m);
    if (m == 0) void'(exp_q0.pop_front());
    else void'(exp_q1.pop_front());
  endtask

  task automatic qpush(input int m, input logic [57:0] e);
    if (m == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  task automatic qclear(input int m);
    if (m == 0) exp_q0.delete();
    else exp_q1.delete();
  endtask

  // Reference: in-flight entries are the queue; a full pipe (2 entries) only
  // accepts while the consumer drains; results appear two cycles after acceptance.
  task automatic monitor_cycle();
    logic both, exp_any, exp_id, exp_rv;
    logic [57:0] h;
    logic [24:0] s0, s1;
    cyc++;
    s0 = {1'b0, req0_a} + {1'b0, req0_b} + {24'd0, req0_cin};
    s1 = {1'b0, req1_a} + {1'b0, req1_b} + {24'd0, req1_cin};
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        chk("ready_in_reset", 32'({r0_rdy[m], r1_rdy[m]}), 32'd0);
        chk("res_valid_in_reset", 32'(rv[m]), 32'd0);
        qclear(m);
        last_acc[m] = 1'b1;
      end else begin
        both    = req0_valid && req1_valid;
        exp_any = (req0_valid || req1_valid) && !(qsize(m) == 2 && !res_ready);
        if (both) exp_id = (m == 1) ? 1'b0 : !last_acc[m];
        else      exp_id = !req0_valid;
        chk("req0_ready", 32'(r0_rdy[m]), 32'(exp_any && !exp_id));
        chk("req1_ready", 32'(r1_rdy[m]), 32'(exp_any && exp_id));
        h      = qhead(m);
        exp_rv = (qsize(m) > 0) && (cyc >= int'(h[57:26]) + 2);
        chk("res_valid", 32'(rv[m]), 32'(exp_rv));
        chk("busy", 32'(bsy[m]), 32'(qsize(m) > 0));
        if (rv[m] && exp_rv) begin
          chk("res_sum", 32'(rsum[m]), 32'(h[24:0]));
          chk("res_id", 32'(rid[m]), 32'(h[25]));
          if (res_ready) qpop(m);
        end
        if (req0_valid && r0_rdy[m]) begin
          qpush(m, {32'(cyc), 1'b0, s0});
          last_acc[m] = 1'b0;
          acc_cnt[m]++;
        end else if (req1_valid && r1_rdy[m]) begin
          qpush(m, {32'(cyc), 1'b1, s1});
          last_acc[m] = 1'b1;
          acc_cnt[m]++;
        end
      end
    end
  endtask

  task automatic set_req(input logic v0, input logic v1);
    req0_valid = v0;
    req1_valid = v1;
    req0_a = 24'($urandom);
    req0_b = 24'($urandom);
    req1_a = 24'($urandom);
    req1_b = 24'($urandom);
    req0_cin = 1'($urandom_range(0, 1));
    req1_cin = 1'($urandom_range(0, 1));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic stimulus();
    int c0, c1, n;
    // reset with both requesters asserting
    set_req(1'b1, 1'b1);
    repeat (3) next_cycle();
    set_req(1'b0, 1'b0);
    rst_n = 1'b1;
    res_ready = 1'b1;
    next_cycle();

    // carry ripples all the way into bit 24
    req0_valid = 1'b1; req0_a = 24'hFFFFFF; req0_b = 24'h000001; req0_cin = 1'b0;
    @(negedge clk);
    chk("d035_ready", 32'({r0_rdy[1], r0_rdy[0]}), 32'd3);
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("d035_adder_a", 32'(aa[m]), 32'hFFFFFF);
      chk("d035_kin", 32'(kin[m]), 32'd0);
      chk("d035_early", 32'(rv[m]), 32'd0);
    end
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("d035_valid", 32'(rv[m]), 32'd1);
      chk("d035_sum", 32'(rsum[m]), 32'h1000000);
      chk("d035_id", 32'(rid[m]), 32'd0);
    end

    // maximum sum with carry-in
    next_cycle();
    req1_valid = 1'b1; req1_a = 24'hFFFFFF; req1_b = 24'hFFFFFF; req1_cin = 1'b1;
    next_cycle();
    req1_valid = 1'b0;
    @(negedge clk);
    for (int m = 0; m < 2; m++) chk("d036_kin", 32'(kin[m]), 32'd3);
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("d036_sum", 32'(rsum[m]), 32'h1FFFFFF);
      chk("d036_id", 32'(rid[m]), 32'd1);
    end

    // continuous contention at full throughput
    next_cycle();
    c0 = acc_cnt[0];
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 1'b1);
      next_cycle();
    end
    chk("d037_accepts", 32'(acc_cnt[0] - c0), 32'd8);
    set_req(1'b0, 1'b0);
    repeat (4) next_cycle();

    // stalled consumer: pipe holds exactly two
    res_ready = 1'b0;
    set_req(1'b1, 1'b1);
    c0 = acc_cnt[0];
    c1 = acc_cnt[1];
    repeat (5) next_cycle();
    chk("d038_accepts_rr", 32'(acc_cnt[0] - c0), 32'd2);
    chk("d038_accepts_fp", 32'(acc_cnt[1] - c1), 32'd2);
    set_req(1'b0, 1'b0);
    res_ready = 1'b1;
    repeat (5) next_cycle();

    // fixed priority starves req1 until req0 drops
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 1'b1);
      @(negedge clk);
      chk("d040_fp_grant", 32'({r1_rdy[1], r0_rdy[1]}), 32'd1);
      next_cycle();
    end
    req0_valid = 1'b0;
    @(negedge clk);
    chk("d040_fp_req1", 32'(r1_rdy[1]), 32'd1);
    next_cycle();
    set_req(1'b0, 1'b0);
    repeat (3) next_cycle();

    // reset with both stages full
    res_ready = 1'b0;
    set_req(1'b1, 1'b1);
    repeat (3) next_cycle();
    #1;
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("d039_res_valid", 32'(rv[m]), 32'd0);
      chk("d039_busy", 32'(bsy[m]), 32'd0);
    end
    repeat (2) next_cycle();
    rst_n = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("d039_first_grant", 32'({r1_rdy[0], r0_rdy[0]}), 32'd1);
    next_cycle();

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      set_req(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 60));
      res_ready = ($urandom_range(0, 99) < 70);
      next_cycle();
    end

    set_req(1'b0, 1'b0);
    res_ready = 1'b1;
    n = 0;
    while ((bsy != 2'b00) && n < 20) begin
      next_cycle();
      n++;
    end
    @(negedge clk);
    chk("drain_timeout", 32'(n < 20), 32'd1);
    chk("drain_empty", 32'(qsize(0) + qsize(1)), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    res_ready = 1'b0;
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
    last_acc[0] = 1'b1;
    last_acc[1] = 1'b1;
    set_req(1'b0, 1'b0);
    fork
      forever begin
        @(negedge clk);
        monitor_cycle();
      end
      stimulus();
      begin
        #200000;
        errors++;
        $display("FAIL timeout: got no end of stimulus expected end before 200000");
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
